// File: rtl/seq_pkg.sv
// ============================================================================
// Module      : seq_pkg
// Description : Shared constants, state encoding and grid helpers for the
//               step-sequencer playback/edit engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    // Direction request bit positions
    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_DOWN  = 3;

    // Grid geometry
    localparam int NUM_TRACKS = 4;
    localparam int NUM_STEPS  = 16;

    // Tempo denominator: sixteenth notes at 50 MHz when BPM is in beats/min
    localparam int unsigned STEP_DEN_DEFAULT = 750_000_000;

    typedef enum logic [0:0] {
        ST_EDIT = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // Gather one column of the grid; bit r of the result is track r
    function automatic logic [NUM_TRACKS-1:0] column_bits(
        input logic [NUM_TRACKS*NUM_STEPS-1:0] pattern,
        input logic [3:0]                      col
    );
        logic [NUM_TRACKS-1:0] bits;
        for (int r = 0; r < NUM_TRACKS; r++) begin
            bits[r] = pattern[{2'(r), col}];
        end
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tempo_accum.sv
// ============================================================================
// Module      : tempo_accum
// Description : BPM phase accumulator. Adds BPM every cycle and emits a
//               one-cycle step_tick each time the sum reaches STEP_DEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tempo_accum
    import seq_pkg::*;
#(
    parameter int unsigned STEP_DEN = STEP_DEN_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       nReset,
    input  logic       i_clear,
    input  logic [9:0] i_bpm,
    output logic       o_step_tick
);

    localparam logic [31:0] c_den = 32'(STEP_DEN);

    logic [30:0] r_acc;
    logic [31:0] w_sum;
    logic        w_wrap;

    // One spare bit so acc+BPM never overflows before the compare
    assign w_sum       = {1'b0, r_acc} + {22'd0, i_bpm};
    assign w_wrap      = (w_sum >= c_den);
    assign o_step_tick = w_wrap & ~i_clear;

    // Phase accumulator, held at zero while cleared
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (w_wrap) begin
            r_acc <= 31'(w_sum - c_den);
        end else begin
            r_acc <= w_sum[30:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_core.sv
// ============================================================================
// Module      : seq_core
// Description : Step-sequencer playback and edit engine. Edits a 4x16 grid
//               with a cursor in EDIT, plays it back with per-track trigger
//               pulses at the programmed tempo in PLAY.
// Options     : SEQ_METRONOME_EN adds a Click output on steps 0/4/8/12.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_core
    import seq_pkg::*;
#(
    parameter int unsigned STEP_DEN = STEP_DEN_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        nReset,
    input  logic [9:0]  BPM,
    input  logic [6:0]  Loops,
    input  logic [3:0]  Direction,
    input  logic        Command,
    input  logic        Start,
    output logic        play_en,
    output logic [3:0]  Trigger,
    output logic [3:0]  play_step,
    output logic [1:0]  cursor_row,
    output logic [3:0]  cursor_col,
`ifdef SEQ_METRONOME_EN
    output logic        Click,
`endif
    output logic [63:0] Pattern
);

    state_t      r_state, w_state_n;
    logic [3:0]  r_dir_q, r_dir_edge;
    logic        r_cmd_q, r_cmd_edge;
    logic        r_start_q, r_start_edge;
    logic [1:0]  r_cursor_row, w_row_n;
    logic [3:0]  r_cursor_col, w_col_n;
    logic [63:0] r_pattern, w_pattern_n;
    logic [3:0]  r_play_step, w_step_n;
    logic [6:0]  r_loops_left, w_loops_n;
    logic [3:0]  r_trigger;
    logic        w_enter;
    logic        w_step_tick;
    logic [5:0]  w_cell;

    tempo_accum #(
        .STEP_DEN    (STEP_DEN)
    ) u_tempo (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .i_clear     (r_state == ST_EDIT),
        .i_bpm       (BPM),
        .o_step_tick (w_step_tick)
    );

    assign w_cell = {r_cursor_row, r_cursor_col};

    // Register each request input and latch its 0->1 transition as a pulse
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_dir_q      <= '0;
            r_dir_edge   <= '0;
            r_cmd_q      <= 1'b0;
            r_cmd_edge   <= 1'b0;
            r_start_q    <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_dir_q      <= Direction;
            r_dir_edge   <= Direction & ~r_dir_q;
            r_cmd_q      <= Command;
            r_cmd_edge   <= Command & ~r_cmd_q;
            r_start_q    <= Start;
            r_start_edge <= Start & ~r_start_q;
        end
    end

    // Next-state logic: cursor/grid edits in EDIT, step sequencing in PLAY
    always_comb begin
        w_state_n   = r_state;
        w_row_n     = r_cursor_row;
        w_col_n     = r_cursor_col;
        w_pattern_n = r_pattern;
        w_step_n    = r_play_step;
        w_loops_n   = r_loops_left;
        w_enter     = 1'b0;
        case (r_state)
            ST_EDIT: begin
                if (r_start_edge) begin
                    w_state_n = ST_PLAY;
                    w_step_n  = 4'd0;
                    w_loops_n = (Loops == 7'd0) ? 7'd1 : Loops;
                    w_enter   = 1'b1;
                end else begin
                    // Toggle uses the cursor position before any move
                    if (r_cmd_edge) begin
                        w_pattern_n = r_pattern ^ (64'd1 << w_cell);
                    end
                    if (r_dir_edge[DIR_RIGHT]) begin
                        w_col_n = r_cursor_col + 4'd1;
                    end else if (r_dir_edge[DIR_LEFT]) begin
                        w_col_n = r_cursor_col - 4'd1;
                    end else if (r_dir_edge[DIR_UP]) begin
                        w_row_n = r_cursor_row - 2'd1;
                    end else if (r_dir_edge[DIR_DOWN]) begin
                        w_row_n = r_cursor_row + 2'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (!Start) begin
                    w_state_n = ST_EDIT;
                    w_step_n  = 4'd0;
                end else if (w_step_tick) begin
                    if (r_play_step != 4'(NUM_STEPS - 1)) begin
                        w_step_n = r_play_step + 4'd1;
                        w_enter  = 1'b1;
                    end else if (r_loops_left > 7'd1) begin
                        w_step_n  = 4'd0;
                        w_loops_n = r_loops_left - 7'd1;
                        w_enter   = 1'b1;
                    end else begin
                        w_state_n = ST_EDIT;
                        w_step_n  = 4'd0;
                    end
                end
            end
            default: w_state_n = ST_EDIT;
        endcase
    end

    // Architectural state and the registered trigger pulse
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_state      <= ST_EDIT;
            r_cursor_row <= '0;
            r_cursor_col <= '0;
            r_pattern    <= '0;
            r_play_step  <= '0;
            r_loops_left <= '0;
            r_trigger    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_cursor_row <= w_row_n;
            r_cursor_col <= w_col_n;
            r_pattern    <= w_pattern_n;
            r_play_step  <= w_step_n;
            r_loops_left <= w_loops_n;
            r_trigger    <= w_enter ? column_bits(r_pattern, w_step_n) : 4'd0;
        end
    end

`ifdef SEQ_METRONOME_EN
    logic r_click;

    // Metronome accent on every fourth step entry, independent of the grid
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            r_click <= 1'b0;
        end else begin
            r_click <= w_enter && (w_step_n[1:0] == 2'b00);
        end
    end

    assign Click = r_click;
`endif

    assign play_en    = (r_state == ST_PLAY);
    assign Trigger    = r_trigger;
    assign play_step  = r_play_step;
    assign cursor_row = r_cursor_row;
    assign cursor_col = r_cursor_col;
    assign Pattern    = r_pattern;

endmodule

`default_nettype wire

// File: tb/tb_seq_core.sv
// ============================================================================
// Module      : tb_seq_core
// Description : Self-checking bench for seq_core with a behavioural model of
//               the cursor/grid and a closed-form tempo model for playback.
// Options     : SEQ_METRONOME_EN enables Click checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_core;

    localparam int DEN = 100;

    logic        CLOCK_50 = 1'b0;
    logic        nReset;
    logic [9:0]  BPM;
    logic [6:0]  Loops;
    logic [3:0]  Direction;
    logic        Command;
    logic        Start;
    logic        play_en;
    logic [3:0]  Trigger;
    logic [3:0]  play_step;
    logic [1:0]  cursor_row;
    logic [3:0]  cursor_col;
    logic [63:0] Pattern;
`ifdef SEQ_METRONOME_EN
    logic        Click;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the editable state
    logic [1:0]  m_row;
    logic [3:0]  m_col;
    logic [63:0] m_pat;

    seq_core #(.STEP_DEN(DEN)) dut (
        .CLOCK_50   (CLOCK_50),
        .nReset     (nReset),
        .BPM        (BPM),
        .Loops      (Loops),
        .Direction  (Direction),
        .Command    (Command),
        .Start      (Start),
        .play_en    (play_en),
        .Trigger    (Trigger),
        .play_step  (play_step),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
`ifdef SEQ_METRONOME_EN
        .Click      (Click),
`endif
        .Pattern    (Pattern)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Column c of a grid: track r is bit r*16+c
    function automatic logic [3:0] col_of(input logic [63:0] pat, input int c);
        logic [3:0] b;
        for (int r = 0; r < 4; r++) b[r] = pat[r*16 + c];
        return b;
    endfunction

    // One edit request: raise inputs for one cycle, then wait for the result
    task automatic op(input logic [3:0] mask, input logic cmd);
        @(negedge CLOCK_50);
        Direction = mask;
        Command   = cmd;
        @(negedge CLOCK_50);
        Direction = 4'd0;
        Command   = 1'b0;
        @(negedge CLOCK_50);
        if (cmd) m_pat[{m_row, m_col}] = ~m_pat[{m_row, m_col}];
        if (mask[0])      m_col = m_col + 4'd1;
        else if (mask[1]) m_col = m_col - 4'd1;
        else if (mask[2]) m_row = m_row - 2'd1;
        else if (mask[3]) m_row = m_row + 2'd1;
    endtask

    task automatic goto_cell(input int r, input int c);
        for (int k = 0; k < 16 && m_col != 4'(c); k++) op(4'b0001, 1'b0);
        for (int k = 0; k < 4 && m_row != 2'(r); k++) op(4'b1000, 1'b0);
    endtask

    // Walk the whole grid, toggling cells that differ from the target
    task automatic set_pattern(input logic [63:0] target);
        goto_cell(0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                op(4'b0001, m_pat[r*16 + c] != target[r*16 + c]);
            end
            op(4'b1000, 1'b0);
        end
    endtask

    task automatic test_reset;
        nReset = 1'b0; BPM = '0; Loops = '0; Direction = '0; Command = 1'b0; Start = 1'b0;
        m_row = '0; m_col = '0; m_pat = '0;
        repeat (3) @(negedge CLOCK_50);
        nReset = 1'b1;
        @(negedge CLOCK_50);
        n_tests++;
        if ({play_en, Trigger, play_step, cursor_row, cursor_col, Pattern} !== 79'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%0b trig=%h step=%0d row=%0d col=%0d pat=%h required all zero",
                     play_en, Trigger, play_step, cursor_row, cursor_col, Pattern);
        end
`ifdef SEQ_METRONOME_EN
        n_tests++;
        if (Click !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_click got %0b required 0", Click);
        end
`endif
    endtask

    task automatic test_edit_basic;
        // Two-cycle edit latency on the first move
        @(negedge CLOCK_50);
        Direction = 4'b0001;
        @(negedge CLOCK_50);
        n_tests++;
        if (cursor_col !== 4'd0) begin
            n_fail++;
            $display("FAIL edit_latency_early got col=%0d required 0", cursor_col);
        end
        Direction = 4'b0000;
        @(negedge CLOCK_50);
        n_tests++;
        if (cursor_col !== 4'd1) begin
            n_fail++;
            $display("FAIL edit_latency_late got col=%0d required 1", cursor_col);
        end
        m_col = 4'd1;
        op(4'b0001, 1'b0);
        op(4'b0001, 1'b0);
        op(4'b0100, 1'b0);
        op(4'b0100, 1'b0);
        op(4'b0000, 1'b1);
        n_tests++;
        if (cursor_row !== 2'd2 || cursor_col !== 4'd3 || Pattern !== (64'd1 << 35)) begin
            n_fail++;
            $display("FAIL edit_toggle_set got row=%0d col=%0d pat=%h required row=2 col=3 pat=%h",
                     cursor_row, cursor_col, Pattern, 64'd1 << 35);
        end
        op(4'b0000, 1'b1);
        n_tests++;
        if (Pattern !== 64'd0) begin
            n_fail++;
            $display("FAIL edit_toggle_clear got pat=%h required 0", Pattern);
        end
    endtask

    task automatic test_wrap;
        logic [3:0] col_before;
        for (int k = 0; k < 16 && m_col != 4'd0; k++) op(4'b0010, 1'b0);
        op(4'b0010, 1'b0);
        n_tests++;
        if (cursor_col !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_left got col=%0d required 15", cursor_col);
        end
        for (int k = 0; k < 4 && m_row != 2'd3; k++) op(4'b1000, 1'b0);
        op(4'b1000, 1'b0);
        n_tests++;
        if (cursor_row !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_down got row=%0d required 0", cursor_row);
        end
        col_before = m_col;
        @(negedge CLOCK_50);
        Direction = 4'b0001;
        repeat (100) @(negedge CLOCK_50);
        Direction = 4'b0000;
        repeat (2) @(negedge CLOCK_50);
        m_col = col_before + 4'd1;
        n_tests++;
        if (cursor_col !== m_col) begin
            n_fail++;
            $display("FAIL hold_single_move got col=%0d required %0d", cursor_col, m_col);
        end
    endtask

    task automatic test_random_edit;
        for (int i = 0; i < 40; i++) begin
            op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            n_tests++;
            if ({cursor_row, cursor_col, Pattern} !== {m_row, m_col, m_pat}) begin
                n_fail++;
                $display("FAIL random_edit op=%0d got row=%0d col=%0d pat=%h required row=%0d col=%0d pat=%h",
                         i, cursor_row, cursor_col, Pattern, m_row, m_col, m_pat);
            end
        end
    endtask

    // Start a play and check every cycle against floor(t*BPM/DEN) step counting
    task automatic play_check(input int loops_in, input int bpm_in, input int abort_step, input string name);
        int  L, s, sp, t, limit;
        bit  ended, entry, done;
        logic [3:0] exp_trig;
        L     = (loops_in == 0) ? 1 : loops_in;
        limit = (abort_step >= 0) ? abort_step - 2 : 16*L - 3;
        @(negedge CLOCK_50);
        BPM = 10'(bpm_in); Loops = 7'(loops_in); Start = 1'b1;
        @(negedge CLOCK_50);
        n_tests++;
        if (play_en !== 1'b0 || Trigger !== 4'd0) begin
            n_fail++;
            $display("FAIL %s start_latency got en=%0b trig=%b required en=0 trig=0000", name, play_en, Trigger);
        end
        @(negedge CLOCK_50);
        sp = -1; t = 0; done = 0;
        while (!done && t < 6000) begin
            s        = (t * bpm_in) / DEN;
            ended    = (s >= 16*L);
            entry    = !ended && (t == 0 || s != sp);
            exp_trig = entry ? col_of(m_pat, s % 16) : 4'd0;
            n_tests++;
            if (play_en !== !ended || Trigger !== exp_trig || play_step !== (ended ? 4'd0 : 4'(s % 16))) begin
                n_fail++;
                $display("FAIL %s play t=%0d got en=%0b trig=%b step=%0d required en=%0b trig=%b step=%0d",
                         name, t, play_en, Trigger, play_step, !ended, exp_trig, ended ? 0 : s % 16);
            end
`ifdef SEQ_METRONOME_EN
            n_tests++;
            if (Click !== (entry && (s % 4 == 0))) begin
                n_fail++;
                $display("FAIL %s click t=%0d got %0b required %0b", name, t, Click, entry && (s % 4 == 0));
            end
`endif
            if (ended) begin
                done = 1;
            end else if (abort_step >= 0 && s == abort_step && entry) begin
                Start = 1'b0;
                done  = 1;
            end else begin
                if (s >= 1 && s <= limit) begin
                    Direction = 4'($urandom);
                    Command   = 1'($urandom);
                end else begin
                    Direction = 4'd0;
                    Command   = 1'b0;
                end
                sp = s;
                t++;
                @(negedge CLOCK_50);
            end
        end
        Direction = 4'd0;
        Command   = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout got no end of play required end within 6000 cycles", name);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK_50);
            n_tests++;
            if (play_en !== 1'b0 || Trigger !== 4'd0) begin
                n_fail++;
                $display("FAIL %s after_play k=%0d got en=%0b trig=%b required en=0 trig=0000",
                         name, k, play_en, Trigger);
            end
        end
        Start = 1'b0;
        @(negedge CLOCK_50);
        n_tests++;
        if ({cursor_row, cursor_col, Pattern} !== {m_row, m_col, m_pat}) begin
            n_fail++;
            $display("FAIL %s edit_preserved got row=%0d col=%0d pat=%h required row=%0d col=%0d pat=%h",
                     name, cursor_row, cursor_col, Pattern, m_row, m_col, m_pat);
        end
    endtask

    task automatic test_play_two_loops;
        set_pattern(64'h0000_0000_0010_0001);
        play_check(2, 25, -1, "play_two_loops");
    endtask

    task automatic test_play_loops_zero;
        play_check(0, 25, -1, "play_loops_zero");
    endtask

    task automatic test_abort;
        set_pattern({$urandom, $urandom});
        play_check(1, 25, 5, "abort");
    endtask

    task automatic test_random_play;
        for (int i = 0; i < 3; i++) begin
            set_pattern({$urandom, $urandom});
            play_check($urandom_range(0, 3), $urandom_range(10, 100), -1, "random_play");
        end
    endtask

`ifdef SEQ_METRONOME_EN
    task automatic test_metronome;
        play_check(1, 50, -1, "metronome");
    endtask
`endif

    task automatic test_async_reset;
        set_pattern({$urandom, $urandom} | 64'd1);
        goto_cell(1, 5);
        @(negedge CLOCK_50);
        BPM = 10'd25; Loops = 7'd3; Start = 1'b1;
        repeat (15) @(negedge CLOCK_50);
        n_tests++;
        if (play_en !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_precond got en=%0b required 1", play_en);
        end
        #2 nReset = 1'b0;
        #1;
        n_tests++;
        if ({play_en, Trigger, play_step, cursor_row, cursor_col, Pattern} !== 79'd0) begin
            n_fail++;
            $display("FAIL async_reset got en=%0b trig=%b step=%0d row=%0d col=%0d pat=%h required all zero",
                     play_en, Trigger, play_step, cursor_row, cursor_col, Pattern);
        end
        Start = 1'b0;
        @(negedge CLOCK_50);
        nReset = 1'b1;
        m_row = '0; m_col = '0; m_pat = '0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        test_reset();
        test_edit_basic();
        test_wrap();
        test_random_edit();
        test_play_two_loops();
        test_play_loops_zero();
        test_abort();
        test_random_play();
`ifdef SEQ_METRONOME_EN
        test_metronome();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/seq_core.md
# seq_core

Playback and edit engine for the step sequencer, directly downstream of the keyboard input interface. It consumes BPM, Loops, Direction, Command and Start, and holds a 4-track x 16-step pattern grid. In edit mode it moves a cursor and toggles grid cells. In play mode it advances a step pointer at the programmed tempo and emits per-track trigger pulses. It drives play_en back to the input interface so that interface leaves its play mode when playback finishes.

## Interface
- STEP_DEN, 750_000_000: tempo denominator; steps/s = BPM*CLK_HZ/STEP_DEN (sixteenth notes at 50 MHz).
- CLOCK_50  in  1  system clock
- nReset  in  1  reset, asynchronous, active-low
- BPM  in  10  tempo, sampled every cycle
- Loops  in  7  passes per play; 0 treated as 1
- Direction  in  4  move request, level: [0] right, [1] left, [2] up, [3] down
- Command  in  1  toggle request, level
- Start  in  1  play request, level
- play_en  out  1  high while playing
- Trigger  out  4  one-cycle pulse per track on step entry
- play_step  out  4  current play column
- cursor_row  out  2  edit cursor track
- cursor_col  out  4  edit cursor step
- Pattern  out  64  grid, bit = row*16+col

## Operation
- States:
  - EDIT: reset state.
  - PLAY.
- Rising edges of Direction (any bit 0→1 while the previous value was 0), Command and Start are detected with one registered copy of each input.
- EDIT behaviour:
  - Direction edge moves the cursor with wrap-around: col 15+right→0, col 0+left→15, row 0+up→3, row 3+down→0.
  - If more than one Direction bit rises together, priority is right > left > up > down.
  - Command edge toggles Pattern[cursor_row*16+cursor_col].
  - A Command edge and a Direction edge in the same cycle: toggle the old cursor cell, then move.
- Start edge in EDIT causes the following on the next cycle:
  - PLAY, play_en=1, play_step=0, accumulator=0.
  - loops_left = (Loops==0) ? 1 : Loops.
  - Trigger = column 0 bits.
- In PLAY:
  - Cursor moves and Command are ignored.
  - Accumulator: if acc+BPM >= STEP_DEN then acc ← acc+BPM−STEP_DEN and a step event occurs; else acc ← acc+BPM. Width is 31 bits. BPM=0 freezes playback.
- Step event handling:
  - At play_step<15: play_step+1, Trigger = new column.
  - At play_step==15 with loops_left>1: play_step=0, loops_left−1, Trigger = column 0.
  - At play_step==15 with loops_left==1: EDIT, play_en=0, play_step=0, no Trigger.
- Start low while in PLAY (abort): EDIT on the next cycle, play_en=0, no Trigger. The cursor and Pattern are preserved.
- Column c, track r bit = Pattern[r*16+c]. Trigger[r] is that bit.

## Timing
- Reset values: play_en=0, Trigger=0, play_step=0, cursor_row=0, cursor_col=0, Pattern=0, accumulator=0, edge registers=0.
- Edit latency: the input edge appears at the outputs 2 cycles after the input changes (edge register, then state update).
- Trigger is high for exactly 1 cycle per step entry. It is 0 at all other times.
- Step period in cycles is STEP_DEN/BPM on average; jitter is ≤1 cycle.
- Start held high after playback ends does not restart play; a new 0→1 edge is required.
- Asynchronous reset mid-play returns immediately to reset values.

## Configuration
- SEQ_METRONOME_EN defined:
  - Adds output Click (1 bit).
  - Click pulses 1 cycle together with Trigger timing on step entry when play_step[1:0]==0 (steps 0, 4, 8, 12), regardless of Pattern.
- SEQ_METRONOME_EN undefined: the Click port and its logic are absent.
- All other behaviour is identical in both cases.

## Structure
- Package seq_pkg holds:
  - Direction bit indices (DIR_RIGHT=0, DIR_LEFT=1, DIR_UP=2, DIR_DOWN=3).
  - NUM_TRACKS=4, NUM_STEPS=16.
  - State encodings for EDIT and PLAY.
  - STEP_DEN default.
- Sub-module tempo_accum:
  - Holds the BPM phase accumulator.
  - Inputs: clear, BPM.
  - Output: step_tick, a 1-cycle pulse.
- seq_core instantiates tempo_accum and contains the FSM, cursor, grid and loop counter.

## Test plan
- Reset, then: three right edges, two up edges, one Command edge. Required: cursor_row=2, cursor_col=3, Pattern bit 35=1. A second Command edge clears bit 35.
- Cursor at col 0, left edge: cursor_col=15. Cursor at row 3, down edge: cursor_row=0. Direction held high for 100 cycles produces one move only.
- STEP_DEN=100, BPM=25, Loops=2, Pattern bits 0 and 20 set, Start edge. Required:
  - A step every 4 cycles.
  - Trigger=0001 at steps 0 in both passes.
  - Trigger=0010 at step 4 in both passes.
  - play_en falls after 32 steps.
- STEP_DEN=100, BPM=25, Loops=0, Start edge: a single 16-step pass, then play_en=0. Start still high produces no restart.
- Start dropped at step 5 of play: EDIT the next cycle, play_en=0, no further Trigger, Pattern unchanged.
- With SEQ_METRONOME_EN, STEP_DEN=100, BPM=50: Click pulses at steps 0, 4, 8 and 12, i.e. every 8 cycles; Click=0 in EDIT.
